// File: rtl/execute_muldiv_if.sv
// execute_muldiv_if
// Groups the Execute-stage signals that connect the RV32M multiply/divide
// unit to the surrounding pipeline.
//   master : pipeline side (drives StartE, FlushE, Funct3E, SrcAE, SrcBE)
//   slave  : multiply/divide unit (drives BusyE, DoneE, ResultE)
interface execute_muldiv_if;
   logic        StartE;
   logic        FlushE;
   logic [2:0]  Funct3E;
   logic [31:0] SrcAE;
   logic [31:0] SrcBE;
   logic        BusyE;
   logic        DoneE;
   logic [31:0] ResultE;

   modport master (
      output StartE, FlushE, Funct3E, SrcAE, SrcBE,
      input  BusyE, DoneE, ResultE
   );

   modport slave (
      input  StartE, FlushE, Funct3E, SrcAE, SrcBE,
      output BusyE, DoneE, ResultE
   );
endinterface

// File: rtl/execute_muldiv.sv
// execute_muldiv
// Iterative RV32M multiply/divide unit for the Execute stage. It does one
// shift-add (multiply) or restoring shift-subtract (divide) step per cycle
// on operand magnitudes, then fixes the sign and selects the result.
// Ports:
//   clk   : pipeline clock, rising edge
//   reset : synchronous, active-high
//   bus   : execute_muldiv_if.slave
//           StartE/FlushE/Funct3E/SrcAE/SrcBE in, BusyE/DoneE/ResultE out
module execute_muldiv (
   input  logic            clk,
   input  logic            reset,
   execute_muldiv_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      state_r;
   state_t      state_next_s;
   logic [4:0]  cnt_r;
   logic [2:0]  funct3_r;
   logic [31:0] mag_a_r;
   logic [31:0] mag_b_r;
   logic        neg_res_r;
   logic        neg_rem_r;
   logic [63:0] prod_r;
   logic [31:0] rem_r;
   logic [31:0] quo_r;
   logic [31:0] result_r;
   logic        done_r;

   logic        a_signed_s;
   logic        b_signed_s;
   logic        a_neg_s;
   logic        b_neg_s;
   logic [31:0] mag_a_s;
   logic [31:0] mag_b_s;
   logic        accept_s;
   logic        div_zero_s;
   logic        div_ovf_s;
   logic        special_s;
   logic [31:0] special_res_s;
   logic [32:0] mul_sum_s;
   logic [32:0] div_shift_s;
   logic [32:0] div_diff_s;
   logic [63:0] prod_fix_s;
   logic [31:0] quo_fix_s;
   logic [31:0] rem_fix_s;
   logic [31:0] fix_res_s;

   // Two's-complement negate when requested; used for abs() and sign fix.
   function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

   function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
      return neg ? (~v + 64'd1) : v;
   endfunction

   // Decode the incoming op: operand signedness, magnitudes, special cases.
   always_comb begin
      a_signed_s    = 1'b0;
      b_signed_s    = 1'b0;
      special_res_s = 32'd0;
      case (bus.Funct3E)
         // MUL's low half is sign-agnostic, so it shares the signed path
         3'b000, 3'b001, 3'b100, 3'b110: begin
            a_signed_s = 1'b1;
            b_signed_s = 1'b1;
         end
         3'b010: begin
            a_signed_s = 1'b1;
            b_signed_s = 1'b0;
         end
         default: begin
            a_signed_s = 1'b0;
            b_signed_s = 1'b0;
         end
      endcase
      a_neg_s    = a_signed_s & bus.SrcAE[31];
      b_neg_s    = b_signed_s & bus.SrcBE[31];
      mag_a_s    = cond_neg32(bus.SrcAE, a_neg_s);
      mag_b_s    = cond_neg32(bus.SrcBE, b_neg_s);
      accept_s   = (state_r == IDLE) & bus.StartE & ~bus.FlushE;
      div_zero_s = bus.Funct3E[2] & (bus.SrcBE == 32'd0);
      // Signed overflow only for DIV/REM (funct3 bit 0 clear)
      div_ovf_s  = bus.Funct3E[2] & ~bus.Funct3E[0] &
                   (bus.SrcAE == 32'h8000_0000) & (bus.SrcBE == 32'hFFFF_FFFF);
      special_s  = div_zero_s | div_ovf_s;
      // funct3 bit 1 distinguishes remainder ops from quotient ops
      if (div_zero_s) begin
         special_res_s = bus.Funct3E[1] ? bus.SrcAE : 32'hFFFF_FFFF;
      end else if (div_ovf_s) begin
         special_res_s = bus.Funct3E[1] ? 32'd0 : 32'h8000_0000;
      end else begin
         special_res_s = 32'd0;
      end
   end

   // One iteration of the shift-add and restoring-divide datapaths, plus the
   // sign-corrected result selection used in FIX.
   always_comb begin
      // Product register holds {accumulator, remaining multiplier bits}
      mul_sum_s   = {1'b0, prod_r[63:32]} + (prod_r[0] ? {1'b0, mag_a_r} : 33'd0);
      // 33-bit trial remainder: shift in next dividend bit, subtract divisor
      div_shift_s = {rem_r, quo_r[31]};
      div_diff_s  = div_shift_s - {1'b0, mag_b_r};
      prod_fix_s  = cond_neg64(prod_r, neg_res_r);
      quo_fix_s   = cond_neg32(quo_r, neg_res_r);
      rem_fix_s   = cond_neg32(rem_r, neg_rem_r);
      case (funct3_r)
         3'b000:                 fix_res_s = prod_fix_s[31:0];
         3'b001, 3'b010, 3'b011: fix_res_s = prod_fix_s[63:32];
         3'b100, 3'b101:         fix_res_s = quo_fix_s;
         default:                fix_res_s = rem_fix_s;
      endcase
   end

   // Next-state logic; a flush returns to IDLE from any state.
   always_comb begin
      state_next_s = state_r;
      if (bus.FlushE) begin
         state_next_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.StartE) begin
                  state_next_s = special_s ? DONE : CALC;
               end else begin
                  state_next_s = IDLE;
               end
            end
            CALC: begin
               if (cnt_r == 5'd31) begin
                  state_next_s = FIX;
               end else begin
                  state_next_s = CALC;
               end
            end
            FIX:     state_next_s = DONE;
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
         endcase
      end
   end

   // State register, iteration datapath and result register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         cnt_r     <= 5'd0;
         funct3_r  <= 3'd0;
         mag_a_r   <= 32'd0;
         mag_b_r   <= 32'd0;
         neg_res_r <= 1'b0;
         neg_rem_r <= 1'b0;
         prod_r    <= 64'd0;
         rem_r     <= 32'd0;
         quo_r     <= 32'd0;
         result_r  <= 32'd0;
         done_r    <= 1'b0;
      end else begin
         state_r <= state_next_s;
         done_r  <= (state_next_s == DONE);
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  funct3_r  <= bus.Funct3E;
                  mag_a_r   <= mag_a_s;
                  mag_b_r   <= mag_b_s;
                  neg_res_r <= a_neg_s ^ b_neg_s;
                  neg_rem_r <= a_neg_s;
                  cnt_r     <= 5'd0;
                  prod_r    <= {32'd0, mag_b_s};
                  rem_r     <= 32'd0;
                  quo_r     <= mag_a_s;
                  if (special_s) begin
                     result_r <= special_res_s;
                  end
               end
            end
            CALC: begin
               cnt_r <= cnt_r + 5'd1;
               if (funct3_r[2]) begin
                  // Borrow clear: subtraction fits, quotient bit is 1
                  if (!div_diff_s[32]) begin
                     rem_r <= div_diff_s[31:0];
                     quo_r <= {quo_r[30:0], 1'b1};
                  end else begin
                     rem_r <= div_shift_s[31:0];
                     quo_r <= {quo_r[30:0], 1'b0};
                  end
               end else begin
                  prod_r <= {mul_sum_s, prod_r[31:1]};
               end
            end
            FIX: begin
               if (!bus.FlushE) begin
                  result_r <= fix_res_s;
               end
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   // The IDLE term is combinational so the instruction stalls in its first cycle.
   assign bus.BusyE   = ~reset & (accept_s | (state_r == CALC) | (state_r == FIX));
   assign bus.DoneE   = done_r;
   assign bus.ResultE = result_r;

endmodule

// File: tb/tb_execute_muldiv.sv
// tb_execute_muldiv
// Self-checking bench for execute_muldiv: directed vector table, flush and
// reset sequences, back-to-back ops, and randomized ops checked against a
// plain-arithmetic RV32M reference.
module tb_execute_muldiv;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] last_res;

   always #5 clk = ~clk;

   // Free-running cycle counter used to measure spacing between DoneE pulses.
   always @(posedge clk) cyc <= cyc + 1;

   execute_muldiv_if bus ();

   execute_muldiv dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t tbl [12];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // RV32M result computed with 64-bit integer arithmetic.
   function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
      longint          sa, sb, p;
      longint unsigned ua, ub, up;
      logic [63:0]     w;
      logic            ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f3)
         3'd0: begin p = sa * sb; w = p; return w[31:0]; end
         3'd1: begin p = sa * sb; w = p; return w[63:32]; end
         3'd2: begin p = sa * longint'(ub); w = p; return w[63:32]; end
         3'd3: begin up = ua * ub; w = up; return w[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (ovf) return 32'h8000_0000;
            p = sa / sb; w = p; return w[31:0];
         end
         3'd5: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            up = ua / ub; w = up; return w[31:0];
         end
         3'd6: begin
            if (b == 32'd0) return a;
            if (ovf) return 32'd0;
            p = sa % sb; w = p; return w[31:0];
         end
         default: begin
            if (b == 32'd0) return a;
            up = ua % ub; w = up; return w[31:0];
         end
      endcase
   endfunction

   // Cycle index of DoneE relative to the start cycle.
   function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
      if (f3[2] && (b == 32'd0)) return 1;
      if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 34;
   endfunction

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Issue one op starting this cycle, hold StartE until DoneE, check outcome.
   task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat,
                         output int done_glob);
      int          done_at;
      int          busy_n;
      logic [31:0] res;
      done_at   = -1;
      busy_n    = 0;
      res       = 32'd0;
      done_glob = -1;
      bus.StartE  = 1'b1;
      bus.Funct3E = f3;
      bus.SrcAE   = a;
      bus.SrcBE   = b;
      for (int c = 0; c < 60 && done_at < 0; c++) begin
         @(negedge clk);
         if (bus.BusyE) busy_n++;
         if (bus.DoneE) begin
            done_at   = c;
            done_glob = cyc;
            res       = bus.ResultE;
         end
         tick();
      end
      bus.StartE = 1'b0;
      check({name, "_done_cycle"}, done_at, lat);
      check({name, "_busy_cycles"}, busy_n, lat);
      check({name, "_result"}, res, exp);
      last_res = exp;
   endtask

   initial begin
      int          g1;
      int          g2;
      int          done_at;
      int          seen;
      logic [31:0] res;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;

      tbl[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
      tbl[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
      tbl[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
      tbl[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
      tbl[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
      tbl[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
      tbl[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        34};
      tbl[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         34};
      tbl[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
      tbl[9]  = '{3'd7, 32'd5,          32'd0,         32'd5,         1};
      tbl[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
      tbl[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};

      // Reset with StartE asserted: reset must win.
      reset       = 1'b1;
      bus.StartE  = 1'b1;
      bus.FlushE  = 1'b0;
      bus.Funct3E = 3'd0;
      bus.SrcAE   = 32'd5;
      bus.SrcBE   = 32'd3;
      tick();
      @(negedge clk);
      check("reset_busy", bus.BusyE, 0);
      check("reset_done", bus.DoneE, 0);
      check("reset_result", bus.ResultE, 32'd0);
      tick();
      reset      = 1'b0;
      bus.StartE = 1'b0;
      last_res   = 32'd0;
      tick();

      for (int i = 0; i < 12; i++) begin
         run_op($sformatf("vec%0d", i), tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].exp,
                tbl[i].lat, g1);
      end

      // StartE together with FlushE in IDLE is not accepted.
      bus.StartE  = 1'b1;
      bus.FlushE  = 1'b1;
      bus.Funct3E = 3'd0;
      bus.SrcAE   = 32'd9;
      bus.SrcBE   = 32'd9;
      @(negedge clk);
      check("idle_flush_busy", bus.BusyE, 0);
      tick();
      bus.StartE = 1'b0;
      bus.FlushE = 1'b0;
      seen = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (bus.DoneE || bus.BusyE) seen = 1;
         tick();
      end
      check("idle_flush_quiet", seen, 0);

      // Flush in cycle 10 of a DIV.
      bus.StartE  = 1'b1;
      bus.Funct3E = 3'd4;
      bus.SrcAE   = 32'd1000;
      bus.SrcBE   = 32'd7;
      for (int c = 0; c < 10; c++) tick();
      bus.FlushE = 1'b1;
      @(negedge clk);
      check("flush_busy_c10", bus.BusyE, 1);
      tick();
      bus.FlushE = 1'b0;
      bus.StartE = 1'b0;
      @(negedge clk);
      check("flush_busy_c11", bus.BusyE, 0);
      tick();
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.DoneE) seen = 1;
         tick();
      end
      check("flush_no_done", seen, 0);
      check("flush_result_held", bus.ResultE, last_res);
      run_op("mul_after_flush", 3'd0, 32'd3, 32'd4, 32'd12, 34, g1);

      // Reset only in cycle 20 of MULHU, StartE still high after: op restarts.
      bus.StartE  = 1'b1;
      bus.Funct3E = 3'd3;
      bus.SrcAE   = 32'hFFFF_FFFF;
      bus.SrcBE   = 32'hFFFF_FFFF;
      done_at = -1;
      res     = 32'd0;
      for (int c = 0; c < 80 && done_at < 0; c++) begin
         if (c == 20) reset = 1'b1;
         if (c == 21) reset = 1'b0;
         @(negedge clk);
         if (c == 20) check("rst_b_busy_c20", bus.BusyE, 0);
         if (c == 21) begin
            check("rst_b_done_c21", bus.DoneE, 0);
            check("rst_b_result_c21", bus.ResultE, 32'd0);
            check("rst_b_busy_c21", bus.BusyE, 1);
         end
         if (bus.DoneE) begin
            done_at = c;
            res     = bus.ResultE;
         end
         tick();
      end
      bus.StartE = 1'b0;
      check("rst_b_done_cycle", done_at, 55);
      check("rst_b_result", res, 32'hFFFF_FFFE);

      // Reset held in cycles 20-21 of MULHU with StartE high.
      bus.StartE = 1'b1;
      for (int c = 0; c < 20; c++) tick();
      reset = 1'b1;
      @(negedge clk);
      check("rst_a_busy_c20", bus.BusyE, 0);
      tick();
      @(negedge clk);
      check("rst_a_busy_c21", bus.BusyE, 0);
      check("rst_a_done_c21", bus.DoneE, 0);
      check("rst_a_result_c21", bus.ResultE, 32'd0);
      tick();
      reset      = 1'b0;
      bus.StartE = 1'b0;
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.DoneE || bus.BusyE) seen = 1;
         tick();
      end
      check("rst_a_quiet", seen, 0);

      // Back-to-back MUL then DIVU.
      run_op("b2b_mul", 3'd0, 32'd5, 32'd6, 32'd30, 34, g1);
      run_op("b2b_divu", 3'd5, 32'd100, 32'd7, 32'd14, 34, g2);
      check("b2b_spacing", g2 - g1, 35);

      // Randomized ops against the reference.
      for (int i = 0; i < 40; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = rand_operand();
         b  = rand_operand();
         run_op($sformatf("rand%0d_f%0d_%h_%h", i, f3, a, b), f3, a, b,
                ref_result(f3, a, b), ref_latency(f3, a, b), g1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
